// File: rtl/vga_bounce_box_pkg.sv
// Shared timing constants, palette and direction encoding for the bouncing-box pixel stage.
package vga_bounce_box_pkg;

  localparam logic [10:0] HStart  = 11'd241;
  localparam logic [10:0] VStart  = 11'd67;
  localparam logic [10:0] HActive = 11'd799;
  localparam logic [10:0] VActive = 11'd599;
  localparam logic [10:0] Box     = 11'd32;
  localparam logic [10:0] Step    = 11'd2;
  localparam logic [10:0] XMax    = HActive - Box;
  localparam logic [10:0] YMax    = VActive - Box;

  typedef enum logic [1:0] {
    DirDownRight = 2'd0,
    DirDownLeft  = 2'd1,
    DirUpRight   = 2'd2,
    DirUpLeft    = 2'd3
  } dir_e;

  // Packed as {r, g, b}, 4 bits each.
  function automatic logic [11:0] palette(input logic [1:0] idx);
    palette = 12'hFFF;
    unique case (idx)
      2'd0: palette = 12'hFF0;
      2'd1: palette = 12'h0FF;
      2'd2: palette = 12'hF0F;
      2'd3: palette = 12'hFFF;
    endcase
  endfunction

endpackage

// File: rtl/vga_bounce_box_if.sv
// Timing-stage inputs and VGA pin outputs of the bouncing-box pixel stage.
interface vga_bounce_box_if;
  logic [10:0] count_h;
  logic [10:0] count_v;
  logic        hs_in;
  logic        vs_in;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        hs_out;
  logic        vs_out;

  modport master (
    output count_h, count_v, hs_in, vs_in,
    input  r, g, b, hs_out, vs_out
  );

  modport slave (
    input  count_h, count_v, hs_in, vs_in,
    output r, g, b, hs_out, vs_out
  );
endinterface

// File: rtl/vga_box_motion.sv
// Once-per-frame box motion: position, direction FSM, colour index and bounce pulse.
module vga_box_motion
  import vga_bounce_box_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick_i,
  input  logic        enable_i,
  output logic [10:0] x_pos_o,
  output logic [10:0] y_pos_o,
  output logic [1:0]  col_idx_o,
  output logic        bounce_o
);

  dir_e        dir_q, dir_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [1:0]  col_q, col_d;
  logic        bounce_q, bounce_d;
  logic        right, down, next_right, next_down, flip_x, flip_y;

  always_comb begin
    dir_d      = dir_q;
    x_d        = x_q;
    y_d        = y_q;
    col_d      = col_q;
    bounce_d   = 1'b0;
    right      = (dir_q == DirDownRight) || (dir_q == DirUpRight);
    down       = (dir_q == DirDownRight) || (dir_q == DirDownLeft);
    next_right = right;
    next_down  = down;
    flip_x     = 1'b0;
    flip_y     = 1'b0;
    if (frame_tick_i && enable_i) begin
      // Axes are independent; a corner hit still counts as a single bounce.
      if (right) begin
        if (x_q + Step >= XMax) begin
          x_d = XMax; next_right = 1'b0; flip_x = 1'b1;
        end else begin
          x_d = x_q + Step;
        end
      end else if (x_q <= Step) begin
        x_d = '0; next_right = 1'b1; flip_x = 1'b1;
      end else begin
        x_d = x_q - Step;
      end
      if (down) begin
        if (y_q + Step >= YMax) begin
          y_d = YMax; next_down = 1'b0; flip_y = 1'b1;
        end else begin
          y_d = y_q + Step;
        end
      end else if (y_q <= Step) begin
        y_d = '0; next_down = 1'b1; flip_y = 1'b1;
      end else begin
        y_d = y_q - Step;
      end
      unique case ({next_down, next_right})
        2'b11: dir_d = DirDownRight;
        2'b10: dir_d = DirDownLeft;
        2'b01: dir_d = DirUpRight;
        2'b00: dir_d = DirUpLeft;
      endcase
      bounce_d = flip_x | flip_y;
      col_d    = col_q + {1'b0, bounce_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= DirDownRight;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      bounce_q <= 1'b0;
    end else begin
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      bounce_q <= bounce_d;
    end
  end

  assign x_pos_o   = x_q;
  assign y_pos_o   = y_q;
  assign col_idx_o = col_q;
  assign bounce_o  = bounce_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Two-stage pixel pipeline drawing a bouncing box on a black background.
module vga_bounce_box
  import vga_bounce_box_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  vga_bounce_box_if.slave  vga,
  input  logic             enable,
  output logic             bounce
);

  logic [10:0] x_rel_q, x_rel_d, y_rel_q, y_rel_d;
  logic        de_q, de_d, hs1_q, vs1_q, hs2_q, vs2_q;
  logic [11:0] rgb_q, rgb_d;
  logic [10:0] x_pos, y_pos;
  logic [1:0]  col_idx;
  logic        frame_tick, in_box;

  // Counter origin sits in blanking, so updating here never tears the box.
  assign frame_tick = (vga.count_h == '0) && (vga.count_v == '0);

  vga_box_motion u_motion (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (frame_tick),
    .enable_i     (enable),
    .x_pos_o      (x_pos),
    .y_pos_o      (y_pos),
    .col_idx_o    (col_idx),
    .bounce_o     (bounce)
  );

  always_comb begin
    x_rel_d = vga.count_h - HStart;
    y_rel_d = vga.count_v - VStart;
    de_d    = (vga.count_h >= HStart) && (vga.count_h < HStart + HActive) &&
              (vga.count_v >= VStart) && (vga.count_v < VStart + VActive);
    in_box  = de_q && (x_rel_q >= x_pos) && (x_rel_q < x_pos + Box) &&
              (y_rel_q >= y_pos) && (y_rel_q < y_pos + Box);
    rgb_d   = in_box ? palette(col_idx) : 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_rel_q <= '0;
      y_rel_q <= '0;
      de_q    <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      rgb_q   <= '0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
    end else begin
      x_rel_q <= x_rel_d;
      y_rel_q <= y_rel_d;
      de_q    <= de_d;
      hs1_q   <= vga.hs_in;
      vs1_q   <= vga.vs_in;
      rgb_q   <= rgb_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  end

  assign vga.r      = rgb_q[11:8];
  assign vga.g      = rgb_q[7:4];
  assign vga.b      = rgb_q[3:0];
  assign vga.hs_out = hs2_q;
  assign vga.vs_out = vs2_q;

endmodule
